seq_pattern_detector: RTL

Parametrised serial sequence detector. It watches a qualified 1-bit input stream and compares the most recent N bits against a run-time programmable pattern. Each match produces a registered one-cycle pulse and increments a saturating match counter. Overlapping and non-overlapping matching are both supported under run-time mode control. It generalises the fixed 2-bit sound-loop detector and sits between the serial front end and the event logic.

---
 rtl/seq_pattern_detector.sv | 68 ++++++
 1 files changed

// File: rtl/seq_pattern_detector.sv
// Serial sequence detector: matches the last N qualified bits against a
// programmable pattern, with one-cycle match pulse and saturating counter.
module seq_pattern_detector #(
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input  logic             i_clock,
    input  logic             i_areset,
    input  logic             i_in,
    input  logic             i_valid,
    input  logic [N-1:0]     i_pattern,
    input  logic             i_overlap,
    input  logic             i_clear,
    output logic             o_out,
    output logic [CNT_W-1:0] o_count
);

    localparam int FW = $clog2(N + 1);
    localparam logic [FW-1:0] FULL = FW'(N);

    logic [N-1:0]     r_hist;
    logic [FW-1:0]    r_fill;
    logic             r_out;
    logic [CNT_W-1:0] r_count;

    logic [N-1:0]     w_hist_n;
    logic [FW-1:0]    w_fill_n;
    logic             w_match;
    logic             w_sat;

    always_comb begin
        w_hist_n = {r_hist[N-2:0], i_in};
        w_fill_n = (r_fill == FULL) ? FULL : r_fill + FW'(1);
        // Fill gate keeps zero-filled history from producing a false match
        w_match  = (w_fill_n == FULL) && (w_hist_n == i_pattern);
        w_sat    = &r_count;
    end

    always_ff @(posedge i_clock or posedge i_areset) begin
        if (i_areset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
            r_count <= '0;
        end else if (i_clear) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_out   <= 1'b0;
            r_count <= '0;
        end else if (!i_valid) begin
            r_out <= 1'b0;
        end else begin
            r_hist <= w_hist_n;
            r_out  <= w_match;
            if (w_match) begin
                r_fill <= i_overlap ? FULL : '0;
                if (!w_sat)
                    r_count <= r_count + CNT_W'(1);
            end else begin
                r_fill <= w_fill_n;
            end
        end
    end

    assign o_out   = r_out;
    assign o_count = r_count;

endmodule
